mix_seq_ctrl: RTL and testbench
===============================

Name: mix_seq_ctrl

Overview:
- Sequencing controller for the three-inlet serpentine/diffusion-mixer network (inlets soln1, soln2, soln3; one outlet).
- Drives the inlet and outlet valve actuators through a timed prime/run/flush program.
- Inlet opening is staggered so the long soln3 path (triple serpentine) and the soln2 path are primed before soln1 enters.
- Sits between the host/config register block and the valve driver pins; one run per start request.

Parameters:
- CNT_W, 16, width of every dwell-time field and of the internal dwell counter
- RUN_CNT_W, 8, width of the completed-run counter

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  run request; sampled only in IDLE
- abort  input  1  terminate the current run; sampled every cycle
- t_lead3  input  CNT_W  soln3-only prime time, in cycles
- t_lead2  input  CNT_W  soln3+soln2 prime time, in cycles
- t_run  input  CNT_W  all-inlets mixing time, in cycles
- t_flush  input  CNT_W  outlet-only flush time, in cycles
- valve_soln1  output  1  inlet valve soln1 (1 = open)
- valve_soln2  output  1  inlet valve soln2
- valve_soln3  output  1  inlet valve soln3
- valve_out  output  1  outlet valve
- busy  output  1  high in every non-IDLE state
- done  output  1  one-cycle pulse on normal completion
- aborted  output  1  one-cycle pulse when a run is aborted
- state  output  3  current state encoding
- run_cnt  output  RUN_CNT_W  count of normally completed runs

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. While rst is high: state=IDLE, all valves=0, busy=0, done=0, aborted=0, run_cnt=0, dwell counter=0. Reset asserted mid-run closes all valves immediately (asynchronously); no done or aborted pulse is produced.
- State encoding: IDLE=0, PRIME3=1, PRIME2=2, RUN=3, FLUSH=4, DONE=5. Codes 6 and 7 are illegal and return to IDLE on the next edge with all valves closed.
- Outputs: all outputs are registered and are a function of the state register only.
  - IDLE: all valves 0.
  - PRIME3: soln3 open.
  - PRIME2: soln3 and soln2 open.
  - RUN: all three inlets and valve_out open.
  - FLUSH: valve_out only.
  - DONE: all valves 0, done=1.
- Start:
  - In IDLE with start=1 and abort=0, the edge latches t_lead3, t_lead2, t_run and t_flush into shadow registers and moves to PRIME3. busy and valve_soln3 are high immediately after that edge.
  - Config changes during a run have no effect.
  - start is ignored in every state other than IDLE.
- Dwell timing:
  - Each timed state lasts max(N,1) cycles, where N is its latched field; a field of 0 gives 1 cycle.
  - On entry the counter loads max(N,1)-1 and decrements each cycle. The state advances on the edge where the counter equals 0.
  - Sequence: PRIME3 -> PRIME2 -> RUN -> FLUSH -> DONE -> IDLE.
  - DONE lasts exactly 1 cycle, with busy=1 and done=1.
- Completion: run_cnt increments on the DONE->IDLE edge and wraps modulo 2^RUN_CNT_W.
- Abort:
  - abort=1 in PRIME3, PRIME2, RUN or FLUSH moves to IDLE on the next edge, closing all valves.
  - aborted=1 for the first IDLE cycle. No done pulse; run_cnt is unchanged.
  - abort in DONE is ignored: completion stands.
  - abort and start together in IDLE: start is ignored and no aborted pulse is produced.
- Back-to-back runs: start held high restarts on the first IDLE cycle after DONE, so there is 1 idle cycle between runs.
- Valve ordering: valve_soln1 is never open unless valve_soln2, valve_soln3 and valve_out are also open. The bench asserts this every cycle.

Test Plan:
- Nominal run, t_lead3=4, t_lead2=2, t_run=10, t_flush=3, start pulsed 1 cycle:
  - busy high 20 cycles; valve_soln3 high 16; valve_soln2 high 12; valve_soln1 high 10; valve_out high 13.
  - done pulses on cycle 20 after start; run_cnt 0->1.
- All fields 0:
  - each state lasts 1 cycle; busy high 5 cycles; done on the 5th cycle.
- Abort in RUN (2nd RUN cycle) with the nominal config:
  - next cycle state=0 and all valves 0; aborted pulses once.
  - done never asserts; run_cnt unchanged.
- Change t_run from 10 to 2 while in PRIME2, and pulse start mid-run:
  - RUN still lasts 10 cycles; the extra start has no effect.
- Reset mid-FLUSH:
  - valves drop in the same cycle as rst rises, without a clock edge.
  - after release, state=0, run_cnt=0, no done or aborted pulse.
- start held high with RUN_CNT_W=2, 5 consecutive runs:
  - exactly 1 idle cycle between runs.
  - run_cnt sequence 1,2,3,0,1.
  - the valve-ordering assertion never fires.

Source files
------------

// File: rtl/mix_seq_ctrl.sv
// mix_seq_ctrl: timed prime/run/flush valve sequencer for the three-inlet mixer network
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   start             run request, honoured only in IDLE and only without abort
//   abort             ends an active run (PRIME3..FLUSH) on the next edge
//   t_lead3/t_lead2   soln3-only and soln3+soln2 prime times, in cycles
//   t_run/t_flush     all-inlet mixing time and outlet-only flush time, in cycles
//   valve_soln1..3    inlet valves (1 = open)
//   valve_out         outlet valve
//   busy              high in every non-IDLE state
//   done/aborted      one-cycle pulses for normal completion / abort
//   state             current state code
//   run_cnt           completed-run counter, wraps
module mix_seq_ctrl #(
    parameter int CNT_W     = 16,
    parameter int RUN_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CNT_W-1:0]     t_lead3,
    input  logic [CNT_W-1:0]     t_lead2,
    input  logic [CNT_W-1:0]     t_run,
    input  logic [CNT_W-1:0]     t_flush,
    output logic                 valve_soln1,
    output logic                 valve_soln2,
    output logic                 valve_soln3,
    output logic                 valve_out,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic [2:0]           state,
    output logic [RUN_CNT_W-1:0] run_cnt
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRIME3 = 3'd1,
        PRIME2 = 3'd2,
        RUN    = 3'd3,
        FLUSH  = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     r_t_lead2;
    logic [CNT_W-1:0]     r_t_run;
    logic [CNT_W-1:0]     r_t_flush;
    logic                 r_v1;
    logic                 r_v2;
    logic                 r_v3;
    logic                 r_vo;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_aborted;
    logic [RUN_CNT_W-1:0] r_run_cnt;

    state_t               w_nxt;
    logic [CNT_W-1:0]     w_cnt;
    logic                 w_abt;
    logic                 w_start;

    // Counter load for a dwell of max(n,1) cycles.
    function automatic logic [CNT_W-1:0] dw(input logic [CNT_W-1:0] n);
        return (n == '0) ? '0 : n - CNT_W'(1);
    endfunction

    assign w_start = (r_state == IDLE) && start && !abort;
    assign w_abt   = abort && (r_state inside {PRIME3, PRIME2, RUN, FLUSH});

    always_comb begin
        w_nxt = r_state;
        w_cnt = (r_cnt == '0) ? '0 : r_cnt - CNT_W'(1);
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_nxt = PRIME3;
                    w_cnt = dw(t_lead3);
                end
            end
            PRIME3: begin
                if (r_cnt == '0) begin
                    w_nxt = PRIME2;
                    w_cnt = dw(r_t_lead2);
                end
            end
            PRIME2: begin
                if (r_cnt == '0) begin
                    w_nxt = RUN;
                    w_cnt = dw(r_t_run);
                end
            end
            RUN: begin
                if (r_cnt == '0) begin
                    w_nxt = FLUSH;
                    w_cnt = dw(r_t_flush);
                end
            end
            FLUSH: w_nxt = (r_cnt == '0) ? DONE : FLUSH;
            DONE:  w_nxt = IDLE;
            default: begin
                w_nxt = IDLE;
                w_cnt = '0;
            end
        endcase
        // Abort outranks dwell expiry; DONE is excluded so completion stands.
        if (w_abt) begin
            w_nxt = IDLE;
            w_cnt = '0;
        end
    end

    // Outputs are decoded from the next state so they are registered alongside it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_t_lead2 <= '0;
            r_t_run   <= '0;
            r_t_flush <= '0;
            r_v1      <= 1'b0;
            r_v2      <= 1'b0;
            r_v3      <= 1'b0;
            r_vo      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            r_run_cnt <= '0;
        end else begin
            r_state   <= w_nxt;
            r_cnt     <= w_cnt;
            // t_lead3 goes straight into the counter; the later fields are held here.
            if (w_start) begin
                r_t_lead2 <= t_lead2;
                r_t_run   <= t_run;
                r_t_flush <= t_flush;
            end
            r_v3      <= w_nxt inside {PRIME3, PRIME2, RUN};
            r_v2      <= w_nxt inside {PRIME2, RUN};
            r_v1      <= w_nxt == RUN;
            r_vo      <= w_nxt inside {RUN, FLUSH};
            r_busy    <= w_nxt != IDLE;
            r_done    <= w_nxt == DONE;
            r_aborted <= w_abt;
            if (r_state == DONE)
                r_run_cnt <= r_run_cnt + RUN_CNT_W'(1);
        end
    end

    assign valve_soln1 = r_v1;
    assign valve_soln2 = r_v2;
    assign valve_soln3 = r_v3;
    assign valve_out   = r_vo;
    assign busy        = r_busy;
    assign done        = r_done;
    assign aborted     = r_aborted;
    assign state       = r_state;
    assign run_cnt     = r_run_cnt;
endmodule

// File: tb/tb_mix_seq_ctrl.sv
// tb_mix_seq_ctrl: directed table-driven bench for mix_seq_ctrl
module tb_mix_seq_ctrl;
    localparam int CW = 16;
    localparam int RW = 2;

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic [CW-1:0] t_lead3;
    logic [CW-1:0] t_lead2;
    logic [CW-1:0] t_run;
    logic [CW-1:0] t_flush;
    logic          valve_soln1;
    logic          valve_soln2;
    logic          valve_soln3;
    logic          valve_out;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [2:0]    state;
    logic [RW-1:0] run_cnt;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    int ab_seen = 0;
    int exp_rc = 0;

    mix_seq_ctrl #(.CNT_W(CW), .RUN_CNT_W(RW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .t_lead3(t_lead3), .t_lead2(t_lead2), .t_run(t_run), .t_flush(t_flush),
        .valve_soln1(valve_soln1), .valve_soln2(valve_soln2),
        .valve_soln3(valve_soln3), .valve_out(valve_out),
        .busy(busy), .done(done), .aborted(aborted),
        .state(state), .run_cnt(run_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pulse counters and the valve-ordering rule, checked every cycle.
    always @(negedge clk) begin
        if (done) done_seen++;
        if (aborted) ab_seen++;
        checks++;
        if (valve_soln1 && !(valve_soln2 && valve_soln3 && valve_out)) begin
            errors++;
            $display("FAIL valve_order: v1=%0b v2=%0b v3=%0b vo=%0b", valve_soln1, valve_soln2, valve_soln3, valve_out);
        end
    end

    typedef struct {
        logic [CW-1:0] l3, l2, ru, fl;
        int            nb, n3, n2, n1, no;
    } vec_t;

    vec_t tbl[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_st(input int s);
        int n = 0;
        while (int'(state) != s && n < 100) begin
            tick();
            n++;
        end
        chk("wait_state", int'(state), s);
    endtask

    task automatic cfg(input int l3, input int l2, input int ru, input int fl);
        t_lead3 = CW'(l3);
        t_lead2 = CW'(l2);
        t_run   = CW'(ru);
        t_flush = CW'(fl);
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    function automatic int valves();
        return int'({valve_soln1, valve_soln2, valve_soln3, valve_out});
    endfunction

    initial begin
        int nb, n3, n2, n1, no, dpos, cyc, d0, a0;
        tbl[0] = '{16'd4, 16'd2, 16'd10, 16'd3, 20, 16, 12, 10, 13};
        tbl[1] = '{16'd0, 16'd0, 16'd0,  16'd0, 5,  3,  2,  1,  2};
        tbl[2] = '{16'd1, 16'd1, 16'd1,  16'd1, 5,  3,  2,  1,  2};
        tbl[3] = '{16'd3, 16'd0, 16'd5,  16'd2, 12, 9,  6,  5,  7};
        tbl[4] = '{16'd0, 16'd5, 16'd1,  16'd0, 9,  7,  6,  1,  2};
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        cfg(0, 0, 0, 0);
        repeat (2) tick();
        chk("rst_state", int'(state), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;
        tick();
        chk("reset_valves", valves(), 0);
        chk("reset_run_cnt", int'(run_cnt), 0);
        chk("reset_pulses", int'({done, aborted}), 0);
        for (int i = 0; i < 5; i++) begin
            cfg(int'(tbl[i].l3), int'(tbl[i].l2), int'(tbl[i].ru), int'(tbl[i].fl));
            go();
            nb = 0; n3 = 0; n2 = 0; n1 = 0; no = 0; dpos = 0; cyc = 0;
            while (busy && cyc < 200) begin
                nb += int'(busy);
                n3 += int'(valve_soln3);
                n2 += int'(valve_soln2);
                n1 += int'(valve_soln1);
                no += int'(valve_out);
                if (done) dpos = cyc + 1;
                tick();
                cyc++;
            end
            exp_rc = (exp_rc + 1) % 4;
            chk($sformatf("v%0d_busy", i), nb, tbl[i].nb);
            chk($sformatf("v%0d_soln3", i), n3, tbl[i].n3);
            chk($sformatf("v%0d_soln2", i), n2, tbl[i].n2);
            chk($sformatf("v%0d_soln1", i), n1, tbl[i].n1);
            chk($sformatf("v%0d_out", i), no, tbl[i].no);
            chk($sformatf("v%0d_done_pos", i), dpos, tbl[i].nb);
            chk($sformatf("v%0d_run_cnt", i), int'(run_cnt), exp_rc);
            tick();
        end
        cfg(4, 2, 10, 3);
        d0 = done_seen;
        a0 = ab_seen;
        go();
        wait_st(3);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_state", int'(state), 0);
        chk("abort_valves", valves(), 0);
        chk("abort_pulse", int'(aborted), 1);
        chk("abort_busy", int'(busy), 0);
        tick();
        chk("abort_pulse_end", int'(aborted), 0);
        chk("abort_pulse_count", ab_seen - a0, 1);
        chk("abort_no_done", done_seen - d0, 0);
        chk("abort_run_cnt", int'(run_cnt), exp_rc);
        a0 = ab_seen;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_state", int'(state), 0);
        chk("start_abort_no_pulse", int'(aborted), 0);
        cfg(0, 0, 0, 0);
        d0 = done_seen;
        a0 = ab_seen;
        go();
        wait_st(5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        exp_rc = (exp_rc + 1) % 4;
        chk("done_abort_state", int'(state), 0);
        chk("done_abort_run_cnt", int'(run_cnt), exp_rc);
        chk("done_abort_done", done_seen - d0, 1);
        chk("done_abort_no_pulse", ab_seen - a0, 0);
        tick();
        cfg(4, 2, 10, 3);
        go();
        wait_st(2);
        t_run = 16'd2;
        wait_st(3);
        cyc = 0;
        while (int'(state) == 3 && cyc < 50) begin
            start = (cyc == 3);
            cyc++;
            tick();
        end
        start = 1'b0;
        chk("cfg_change_run_len", cyc, 10);
        wait_st(5);
        tick();
        exp_rc = (exp_rc + 1) % 4;
        chk("cfg_change_run_cnt", int'(run_cnt), exp_rc);
        tick();
        chk("cfg_change_no_restart", int'(state), 0);
        t_run = 16'd10;
        go();
        wait_st(4);
        d0 = done_seen;
        a0 = ab_seen;
        #1 rst = 1'b1;
        #1;
        chk("async_rst_valves", valves(), 0);
        chk("async_rst_state", int'(state), 0);
        chk("async_rst_busy", int'(busy), 0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("post_rst_state", int'(state), 0);
        chk("post_rst_run_cnt", int'(run_cnt), 0);
        chk("post_rst_no_pulses", (done_seen - d0) + (ab_seen - a0), 0);
        cfg(0, 0, 0, 0);
        exp_rc = 0;
        start = 1'b1;
        tick();
        for (int r = 0; r < 5; r++) begin
            wait_st(5);
            tick();
            exp_rc = (exp_rc + 1) % 4;
            chk($sformatf("b2b%0d_idle", r), int'(state), 0);
            chk($sformatf("b2b%0d_run_cnt", r), int'(run_cnt), exp_rc);
            if (r == 4) start = 1'b0;
            tick();
            chk($sformatf("b2b%0d_restart", r), int'(state), (r < 4) ? 1 : 0);
        end
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
